// File: rtl/nco_pkg.sv
// Shared types and default constants for the NCO tuning-word controller.
// Holds the handshake state type, the request-select encoding and the
// default word range, step and dwell values.
package nco_pkg;

    localparam int unsigned WORD_W_DEF   = 32;
    localparam logic [31:0] WORD_MIN_DEF = 32'd429496;
    localparam logic [31:0] WORD_MAX_DEF = 32'd4294967;
    localparam logic [31:0] STEP_DEF     = 32'd429496;
    localparam int unsigned DWELL_W_DEF  = 24;
    localparam logic [23:0] DWELL_DEF    = 24'd50000;

    typedef enum logic {
        IDLE,
        WAIT_ACK
    } state_t;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_LOAD,
        SEL_KEY_UP,
        SEL_KEY_DN,
        SEL_SWEEP
    } req_sel_t;

endpackage

// File: rtl/nco_sweep_timer.sv
// Triangle-sweep pacing: dwell counter, sweep direction and sweep request.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   sweep_en       level enable from the board
//   served         the pending sweep request was issued this cycle
//   hit_max/min    the issued sweep word landed on a range limit
//   ack            the NCO acknowledged the outstanding word
//   active         registered sweep_en
//   req            sweep step wanted (held until served)
//   dir            1 = stepping up, 0 = stepping down
module nco_sweep_timer
    import nco_pkg::*;
#(
    parameter int unsigned          DWELL_W = DWELL_W_DEF,
    parameter logic [DWELL_W-1:0]   DWELL   = DWELL_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic sweep_en,
    input  logic served,
    input  logic hit_max,
    input  logic hit_min,
    input  logic ack,
    output logic active,
    output logic req,
    output logic dir
);

    logic [DWELL_W-1:0] cnt;
    // A sweep word is in flight: the dwell restarts only once it is acked.
    logic               busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active <= 1'b0;
            cnt    <= '0;
            req    <= 1'b0;
            busy   <= 1'b0;
            dir    <= 1'b1;
        end else begin
            active <= sweep_en;
            if (ack) begin
                busy <= 1'b0;
            end
            if (served) begin
                req  <= 1'b0;
                busy <= 1'b1;
                if (hit_max) begin
                    dir <= 1'b0;
                end else if (hit_min) begin
                    dir <= 1'b1;
                end
            end
            // Disabling drops an unissued request; an in-flight word still completes.
            if (!active) begin
                cnt <= '0;
                req <= 1'b0;
            end else if (!req && !busy) begin
                if (cnt == DWELL - DWELL_W'(1)) begin
                    req <= 1'b1;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + DWELL_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/nco_tune_ctrl.sv
// Tuning-word controller for the phase-accumulator NCO. Arbitrates host
// loads, key steps and the triangle sweep (fixed priority), clamps each
// word to [WORD_MIN, WORD_MAX] and hands it to the NCO over valid/ack.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   key_up, key_dn         one-clock step pulses
//   sweep_en               sweep enable level
//   load_valid, load_word  host word request
//   load_ready             host request accepted this cycle (combinational)
//   tune_word, tune_valid  word offered to the NCO
//   tune_ack               NCO applied tune_word
//   cur_word               last acknowledged word
//   sweep_active           sweep engine running
module nco_tune_ctrl
    import nco_pkg::*;
#(
    parameter int unsigned          WORD_W   = WORD_W_DEF,
    parameter logic [WORD_W-1:0]    WORD_MIN = WORD_MIN_DEF,
    parameter logic [WORD_W-1:0]    WORD_MAX = WORD_MAX_DEF,
    parameter logic [WORD_W-1:0]    STEP     = STEP_DEF,
    parameter int unsigned          DWELL_W  = DWELL_W_DEF,
    parameter logic [DWELL_W-1:0]   DWELL    = DWELL_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_up,
    input  logic              key_dn,
    input  logic              sweep_en,
    input  logic              load_valid,
    input  logic [WORD_W-1:0] load_word,
    output logic              load_ready,
    output logic [WORD_W-1:0] tune_word,
    output logic              tune_valid,
    input  logic              tune_ack,
    output logic [WORD_W-1:0] cur_word,
    output logic              sweep_active
);

    state_t            state, state_d;
    req_sel_t          sel;
    logic [WORD_W-1:0] tune_word_d, cur_word_d;
    logic              tune_valid_d;
    logic              pend_up, pend_dn, pend_up_d, pend_dn_d;
    logic              eff_up, eff_dn;
    logic              sweep_req, sweep_dir;
    logic [WORD_W:0]   up_sum, dn_floor;
    logic [WORD_W-1:0] up_word, dn_word, load_clamped, sweep_word;

    assign load_ready = load_valid && (state == IDLE);

    // Saturating step and clamp arithmetic, always based on the acked word.
    always_comb begin
        up_sum   = {1'b0, cur_word} + {1'b0, STEP};
        dn_floor = {1'b0, WORD_MIN} + {1'b0, STEP};
        up_word  = (up_sum > {1'b0, WORD_MAX}) ? WORD_MAX : up_sum[WORD_W-1:0];
        dn_word  = ({1'b0, cur_word} < dn_floor) ? WORD_MIN : cur_word - STEP;
        if (load_word < WORD_MIN) begin
            load_clamped = WORD_MIN;
        end else if (load_word > WORD_MAX) begin
            load_clamped = WORD_MAX;
        end else begin
            load_clamped = load_word;
        end
        sweep_word = sweep_dir ? up_word : dn_word;
    end

    // A pulse counts in the cycle it arrives, so a key is served one clock later.
    assign eff_up = pend_up || key_up;
    assign eff_dn = pend_dn || key_dn;

    // Handshake FSM, arbitration and pending-key bookkeeping.
    always_comb begin
        state_d      = state;
        tune_word_d  = tune_word;
        tune_valid_d = tune_valid;
        cur_word_d   = cur_word;
        sel          = SEL_NONE;
        case (state)
            IDLE: begin
                if (load_valid) begin
                    sel = SEL_LOAD;
                end else if (eff_up && !eff_dn) begin
                    sel = SEL_KEY_UP;
                end else if (eff_dn && !eff_up) begin
                    sel = SEL_KEY_DN;
                end else if (sweep_req) begin
                    sel = SEL_SWEEP;
                end
                case (sel)
                    SEL_LOAD:   tune_word_d = load_clamped;
                    SEL_KEY_UP: tune_word_d = up_word;
                    SEL_KEY_DN: tune_word_d = dn_word;
                    SEL_SWEEP:  tune_word_d = sweep_word;
                    default:    tune_word_d = tune_word;
                endcase
                if (sel != SEL_NONE) begin
                    tune_valid_d = 1'b1;
                    state_d      = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (tune_ack) begin
                    cur_word_d   = tune_word;
                    tune_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Opposite keys cancel each other; a served key clears its flag.
        pend_up_d = eff_up && !eff_dn && (sel != SEL_KEY_UP);
        pend_dn_d = eff_dn && !eff_up && (sel != SEL_KEY_DN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tune_word  <= WORD_MIN;
            tune_valid <= 1'b0;
            cur_word   <= WORD_MIN;
            pend_up    <= 1'b0;
            pend_dn    <= 1'b0;
        end else begin
            state      <= state_d;
            tune_word  <= tune_word_d;
            tune_valid <= tune_valid_d;
            cur_word   <= cur_word_d;
            pend_up    <= pend_up_d;
            pend_dn    <= pend_dn_d;
        end
    end

    nco_sweep_timer #(
        .DWELL_W (DWELL_W),
        .DWELL   (DWELL)
    ) u_sweep (
        .clk     (clk),
        .rst     (rst),
        .sweep_en(sweep_en),
        .served  (sel == SEL_SWEEP),
        .hit_max (sweep_word == WORD_MAX),
        .hit_min (sweep_word == WORD_MIN),
        .ack     ((state == WAIT_ACK) && tune_ack),
        .active  (sweep_active),
        .req     (sweep_req),
        .dir     (sweep_dir)
    );

endmodule

// File: tb/tb_nco_tune_ctrl.sv
// Scoreboard bench for nco_tune_ctrl: stimulus pushes expected words,
// a monitor pops them whenever a new word is offered to the NCO.
module tb_nco_tune_ctrl;

    localparam logic [31:0] WMIN  = 32'd429496;
    localparam logic [31:0] WMAX  = 32'd4294967;
    localparam logic [31:0] STEP  = 32'd429496;
    localparam logic [23:0] DWELL = 24'd4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_up = 1'b0, key_dn = 1'b0, sweep_en = 1'b0;
    logic        load_valid = 1'b0;
    logic [31:0] load_word = '0;
    logic        load_ready;
    logic [31:0] tune_word;
    logic        tune_valid;
    logic        tune_ack = 1'b0;
    logic [31:0] cur_word;
    logic        sweep_active;

    int checks = 0;
    int errors = 0;
    int offers = 0;
    int ack_delay = 0;
    logic hold_ack = 1'b0;

    logic [31:0] sbq[$];
    logic [31:0] model_cur = WMIN;
    logic        model_dir = 1'b1;

    nco_tune_ctrl #(
        .WORD_W(32), .WORD_MIN(WMIN), .WORD_MAX(WMAX), .STEP(STEP),
        .DWELL_W(24), .DWELL(DWELL)
    ) dut (
        .clk(clk), .rst(rst), .key_up(key_up), .key_dn(key_dn),
        .sweep_en(sweep_en), .load_valid(load_valid), .load_word(load_word),
        .load_ready(load_ready), .tune_word(tune_word), .tune_valid(tune_valid),
        .tune_ack(tune_ack), .cur_word(cur_word), .sweep_active(sweep_active)
    );

    always #5 clk = ~clk;

    // Reference rules computed with wide integer arithmetic.
    function automatic logic [31:0] ref_up(input logic [31:0] c);
        longint s = longint'(c) + longint'(STEP);
        return (s > longint'(WMAX)) ? WMAX : 32'(s);
    endfunction

    function automatic logic [31:0] ref_dn(input logic [31:0] c);
        longint s = longint'(c) - longint'(STEP);
        return (s < longint'(WMIN)) ? WMIN : 32'(s);
    endfunction

    function automatic logic [31:0] ref_clamp(input logic [31:0] w);
        if (w < WMIN) return WMIN;
        if (w > WMAX) return WMAX;
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_word(input logic [31:0] w);
        sbq.push_back(w);
        model_cur = w;
    endtask

    // Monitor: every rising tune_valid pops one expectation; every ack
    // must leave cur_word equal to the word just offered.
    initial begin : monitor
        logic        prev_valid = 1'b0;
        logic [31:0] last_exp = WMIN;
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (tune_valid && !prev_valid) begin
                    offers++;
                    checks++;
                    if (sbq.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_offer actual=%0d expected=none at %0t", tune_word, $time);
                    end else begin
                        e = sbq.pop_front();
                        last_exp = e;
                        if (tune_word !== e) begin
                            errors++;
                            $display("FAIL tune_word actual=%0d expected=%0d at %0t", tune_word, e, $time);
                        end
                    end
                end
                if (!tune_valid && prev_valid) begin
                    chk("cur_word_after_ack", cur_word, last_exp);
                end
            end
            prev_valid = tune_valid;
        end
    end

    // NCO side: acknowledge each offered word after ack_delay clocks.
    initial begin : acker
        int waited = 0;
        forever begin
            @(negedge clk);
            if (tune_valid && !hold_ack && !rst) begin
                if (waited >= ack_delay) begin
                    tune_ack = 1'b1;
                    waited = 0;
                end else begin
                    tune_ack = 1'b0;
                    waited++;
                end
            end else begin
                tune_ack = 1'b0;
                waited = 0;
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((sbq.size() != 0 || tune_valid) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout actual=%0d expected=0 pending", sbq.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse(input logic up, input logic dn);
        @(negedge clk);
        key_up = up;
        key_dn = dn;
        @(negedge clk);
        key_up = 1'b0;
        key_dn = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] w);
        int n = 0;
        @(negedge clk);
        load_valid = 1'b1;
        load_word  = w;
        #1;
        while (!load_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL load_ready_timeout actual=0 expected=1");
        end
        @(posedge clk);
        #1 load_valid = 1'b0;
    endtask

    initial begin : stim
        logic [31:0] w, e1;
        int ob, bad, n;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_tune_valid", 32'(tune_valid), 32'd0);
        chk("reset_tune_word", tune_word, WMIN);
        chk("reset_cur_word", cur_word, WMIN);
        chk("reset_load_ready", 32'(load_ready), 32'd0);
        chk("reset_sweep_active", 32'(sweep_active), 32'd0);

        // First key step, acked after 3 clocks.
        ack_delay = 3;
        expect_word(ref_up(model_cur));
        pulse(1'b1, 1'b0);
        chk("key_valid_latency", 32'(tune_valid), 32'd1);
        wait_idle();
        chk("first_step_cur", cur_word, 32'd858992);
        chk("first_step_valid_low", 32'(tune_valid), 32'd0);

        // Saturation at both ends.
        ack_delay = 1;
        expect_word(WMAX); do_load(WMAX); wait_idle();
        expect_word(ref_up(model_cur)); pulse(1'b1, 1'b0); wait_idle();
        chk("sat_high", cur_word, WMAX);
        expect_word(WMIN); do_load(WMIN); wait_idle();
        expect_word(ref_dn(model_cur)); pulse(1'b0, 1'b1); wait_idle();
        chk("sat_low", cur_word, WMIN);

        // Load beats a simultaneous key; the key is served afterwards.
        expect_word(ref_clamp(32'hFFFF_FFFF));
        expect_word(ref_up(model_cur));
        @(negedge clk);
        load_valid = 1'b1; load_word = 32'hFFFF_FFFF; key_up = 1'b1;
        #1 chk("prio_load_ready", 32'(load_ready), 32'd1);
        @(negedge clk);
        load_valid = 1'b0; key_up = 1'b0;
        wait_idle();
        chk("prio_final_cur", cur_word, WMAX);

        // Opposite keys in one cycle cancel.
        ob = offers;
        pulse(1'b1, 1'b1);
        repeat (8) @(negedge clk);
        chk("cancel_no_offer", 32'(offers), 32'(ob));

        // Stalled ack: word held, host blocked, then load then key.
        hold_ack = 1'b1;
        e1 = ref_up(model_cur);
        expect_word(e1);
        pulse(1'b1, 1'b0);
        w = $urandom_range(0, 5000000);
        @(negedge clk);
        key_dn = 1'b1; load_valid = 1'b1; load_word = w;
        for (int i = 0; i < 20; i++) begin
            #1;
            chk("stall_tune_word", tune_word, e1);
            chk("stall_load_ready", 32'(load_ready), 32'd0);
            @(negedge clk);
            key_dn = 1'b0;
        end
        expect_word(ref_clamp(w));
        expect_word(ref_dn(model_cur));
        hold_ack = 1'b0;
        n = 0;
        while (!load_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("stall_load_accept", 32'(load_ready), 32'd1);
        @(posedge clk);
        #1 load_valid = 1'b0;
        wait_idle();

        // Randomized requests against the reference rules.
        for (int i = 0; i < 40; i++) begin
            ack_delay = $urandom_range(0, 4);
            case ($urandom_range(0, 3))
                0: begin
                    w = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 5000000);
                    expect_word(ref_clamp(w));
                    do_load(w);
                end
                1: begin expect_word(ref_up(model_cur)); pulse(1'b1, 1'b0); end
                2: begin expect_word(ref_dn(model_cur)); pulse(1'b0, 1'b1); end
                default: begin
                    ob = offers;
                    pulse(1'b1, 1'b1);
                    repeat (6) @(negedge clk);
                    chk("rand_cancel", 32'(offers), 32'(ob));
                end
            endcase
            wait_idle();
        end

        // Triangle sweep from the bottom with immediate ack.
        ack_delay = 0;
        expect_word(WMIN); do_load(WMIN); wait_idle();
        for (int i = 0; i < 24; i++) begin
            w = model_dir ? ref_up(model_cur) : ref_dn(model_cur);
            if (w == WMAX) model_dir = 1'b0;
            else if (w == WMIN) model_dir = 1'b1;
            expect_word(w);
        end
        @(negedge clk);
        sweep_en = 1'b1;
        bad = 0;
        n = 0;
        while (sbq.size() != 0 && n < 2000) begin
            @(negedge clk);
            if (!sweep_active) bad++;
            n++;
        end
        sweep_en = 1'b0;
        chk("sweep_active_held", 32'(bad), 32'd0);
        chk("sweep_words_done", 32'(sbq.size()), 32'd0);
        wait_idle();
        repeat (10) @(negedge clk);
        chk("sweep_active_off", 32'(sweep_active), 32'd0);

        // Reset in the middle of a handshake with a key pending.
        hold_ack = 1'b1;
        expect_word(ref_up(model_cur));
        pulse(1'b1, 1'b0);
        chk("pre_reset_valid", 32'(tune_valid), 32'd1);
        pulse(1'b0, 1'b1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(tune_valid), 32'd0);
        chk("async_rst_cur", cur_word, WMIN);
        chk("async_rst_word", tune_word, WMIN);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        hold_ack = 1'b0;
        model_cur = WMIN;
        model_dir = 1'b1;
        ob = offers;
        repeat (10) @(negedge clk);
        chk("post_reset_no_offer", 32'(offers), 32'(ob));

        // One more step to confirm normal operation after reset.
        expect_word(ref_up(model_cur));
        pulse(1'b1, 1'b0);
        wait_idle();
        chk("post_reset_step", cur_word, 32'd858992);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
